pit_8254_ctrl: RTL and testbench
================================

// Module: pit_8254_ctrl
// PURPOSE
//  Bus front-end and sequencer for three pit_8254_counter instances (PC ports 0x40-0x43).
//  - Decodes CPU I/O cycles into per-counter strobes: set_control_mode, latch_count,
//    latch_status, write, read.
//  - Handles the 8254 read-back command and muxes counter read data.
//  - Generates the shared PIT input clock with a fractional divider.
//  - Turns counter 0 out into an IRQ0 request pulse.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency, Hz
//  PIT_HZ   1_193_182   PIT input clock frequency, Hz; requires 2*PIT_HZ < CLK_HZ
// PORTS
//  clk               in   1   system clock; all logic on posedge
//  reset_n           in   1   asynchronous active-low reset
//  io_address        in   2   port offset: 0..2 counter data, 3 control word
//  io_write          in   1   write strobe, one cycle per access
//  io_read           in   1   read strobe, one cycle per access
//  io_writedata      in   8   write data
//  io_readdata       out  8   read data
//  io_readdatavalid  out  1   one-cycle pulse marking io_readdata valid
//  gate2_in          in   1   speaker gate (port 0x61 bit0)
//  cnt_data_in       out  8   shared data to all counters
//  cnt_set_mode      out  3   per-counter set_control_mode strobe
//  cnt_latch_count   out  3   per-counter latch_count strobe
//  cnt_latch_status  out  3   per-counter latch_status strobe
//  cnt_write         out  3   per-counter write strobe
//  cnt_read          out  3   per-counter read strobe
//  cnt_data_out      in   24  {ctr2, ctr1, ctr0} data_out, combinational from counters
//  cnt_out           in   3   counter out pins
//  pit_clock         out  1   counter clock input, shared by all three counters
//  pit_gate          out  3   counter gates; [0] and [1] tied 1, [2] = gate2_in registered
//  irq0              out  1   one-cycle pulse on each rising edge of cnt_out[0]
// BEHAVIOUR
//  Reset values: all strobes 0; cnt_data_in, io_readdata, accumulator all 0;
//   io_readdatavalid, pit_clock and irq0 0; pit_gate 3'b011; cnt_out[0] history 1.
//  All outputs are registered. Strobes are single-cycle pulses, asserted cycle T+1
//   for an access at cycle T. cnt_data_in = io_writedata in that same T+1 cycle.
//  Write, io_address 0..2 (a): cnt_write[a] pulse.
//  Write, io_address 3, SC = wd[7:6]:
//   - SC 0..2, RW = wd[5:4] == 0: cnt_latch_count[SC] pulse (counter latch command).
//   - SC 0..2, RW != 0: cnt_set_mode[SC] pulse.
//   - SC 3, read-back:
//     - for each i in 0..2 with wd[i+1] == 1: cnt_latch_count[i] pulses if wd[5] == 0.
//     - for each such i: cnt_latch_status[i] pulses if wd[4] == 0.
//     - Both strobes may pulse in the same cycle. No bits selected: no strobes.
//  Read, io_address 0..2 (a):
//   - io_readdata <= cnt_data_out[8a+7:8a], sampled at the end of cycle T,
//     before the counter's read pointer moves.
//   - io_readdatavalid = 1 at T+1; cnt_read[a] pulse at T+1.
//  Read, io_address 3: io_readdata = 8'hFF, valid at T+1, no counter strobe.
//  io_read and io_write in the same cycle: the write is processed normally; the read
//   returns 8'hFF with valid at T+1 and no cnt_read.
//  Back-to-back accesses every cycle are supported; no stall and no buffering beyond
//   one stage.
//  Divider:
//   - acc is 32 bits; each clk: acc += 2*PIT_HZ.
//   - When acc + 2*PIT_HZ >= CLK_HZ: acc <= acc + 2*PIT_HZ - CLK_HZ and pit_clock
//     toggles.
//   - Long-run pit_clock frequency = PIT_HZ exactly.
//   - Each pit_clock level lasts floor or ceil of CLK_HZ/(2*PIT_HZ) clks.
//  irq0: registered edge detect on cnt_out[0] (prev 0, now 1) -> 1-cycle pulse.
//   No pulse for a level held high.
//  Reset mid-access: pending strobes and readdatavalid are dropped.
//   After release, the first edge is processed normally.
// TESTING
//  - Reset release: all strobes 0; pit_gate = 3'b011; pit_clock is 0 and then starts
//    toggling.
//  - Write 0x43 = 8'h34, then 0x40 = 8'h9C, 0x40 = 8'h2E:
//    cnt_set_mode = 3'b001 with cnt_data_in = 8'h34; then two cnt_write[0] pulses
//    carrying 8'h9C and 8'h2E.
//  - Write 0x43 = 8'hC2 (read-back, latch count + status, ctr0):
//    cnt_latch_count = cnt_latch_status = 3'b001 in the same cycle.
//    Write 0x43 = 8'hEE: cnt_latch_status = 3'b111, no latch_count.
//  - cnt_data_out[7:0] = 8'hA5, read 0x40: io_readdata = 8'hA5 with valid at T+1,
//    cnt_read = 3'b001 at T+1. Read 0x43 -> 8'hFF, no cnt_read.
//  - CLK_HZ = 50e6, PIT_HZ = 1_193_182: count 1_193_182 pit_clock rising edges in
//    50e6 clks, +/-1. Each level is 20 or 21 clks.
//  - cnt_out[0] driven 0 -> 1 -> held 1 for 100 clks -> 0 -> 1: exactly two irq0
//    pulses, each 1 cycle. Simultaneous read and write: write strobe fires, read
//    returns 8'hFF.

Source files
------------

// File: rtl/pit_8254_ctrl.sv
// Bus front-end for three 8254 counters: decodes I/O cycles into per-counter strobes,
// muxes read data, divides the system clock down to the PIT clock and generates IRQ0.
module pit_8254_ctrl #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned PIT_HZ = 1_193_182
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  io_address,
  input  logic        io_write,
  input  logic        io_read,
  input  logic [7:0]  io_writedata,
  output logic [7:0]  io_readdata,
  output logic        io_readdatavalid,
  input  logic        gate2_in,
  output logic [7:0]  cnt_data_in,
  output logic [2:0]  cnt_set_mode,
  output logic [2:0]  cnt_latch_count,
  output logic [2:0]  cnt_latch_status,
  output logic [2:0]  cnt_write,
  output logic [2:0]  cnt_read,
  input  logic [23:0] cnt_data_out,
  input  logic [2:0]  cnt_out,
  output logic        pit_clock,
  output logic [2:0]  pit_gate,
  output logic        irq0
);

  localparam logic [31:0] ACC_INC  = 32'(2 * PIT_HZ);
  localparam logic [31:0] ACC_WRAP = 32'(CLK_HZ);

  // Strobe semantics: an access sampled with io_write/io_read high at edge T produces
  // exactly one cycle of the matching strobe (and cnt_data_in/io_readdata) after edge T;
  // there is no ready/backpressure, so every cycle may carry a new access.

  logic [7:0]  data_in_q,      data_in_d;
  logic [2:0]  set_mode_q,     set_mode_d;
  logic [2:0]  latch_count_q,  latch_count_d;
  logic [2:0]  latch_status_q, latch_status_d;
  logic [2:0]  write_q,        write_d;
  logic [2:0]  read_q,         read_d;
  logic [7:0]  rd_data_q,      rd_data_d;
  logic        rd_valid_q,     rd_valid_d;
  logic [31:0] acc_q,          acc_d;
  logic        pit_clock_q,    pit_clock_d;
  logic [2:0]  pit_gate_q,     pit_gate_d;
  logic        out0_prev_q,    out0_prev_d;
  logic        irq0_q,         irq0_d;
  logic [31:0] acc_sum;

  function automatic logic [2:0] onehot3(input logic [1:0] sel);
    logic [2:0] r;
    case (sel)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // Bus write decode: counter data ports and the control word (latch, mode, read-back).
  always_comb begin
    data_in_d      = data_in_q;
    set_mode_d     = 3'b000;
    latch_count_d  = 3'b000;
    latch_status_d = 3'b000;
    write_d        = 3'b000;
    if (io_write) begin
      data_in_d = io_writedata;
      if (io_address != 2'd3) begin
        write_d = onehot3(io_address);
      end else if (io_writedata[7:6] == 2'd3) begin
        for (int i = 0; i < 3; i++) begin
          latch_count_d[i]  = io_writedata[i+1] & ~io_writedata[5];
          latch_status_d[i] = io_writedata[i+1] & ~io_writedata[4];
        end
      end else if (io_writedata[5:4] == 2'd0) begin
        latch_count_d = onehot3(io_writedata[7:6]);
      end else begin
        set_mode_d = onehot3(io_writedata[7:6]);
      end
    end
  end

  // Read path: data is captured before the counter sees its read strobe.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = io_read;
    read_d     = 3'b000;
    if (io_read) begin
      if (io_write || io_address == 2'd3) begin
        rd_data_d = 8'hFF;
      end else begin
        read_d = onehot3(io_address);
        case (io_address)
          2'd0:    rd_data_d = cnt_data_out[7:0];
          2'd1:    rd_data_d = cnt_data_out[15:8];
          default: rd_data_d = cnt_data_out[23:16];
        endcase
      end
    end
  end

  // Fractional divider: pit_clock toggles whenever the accumulator crosses CLK_HZ.
  always_comb begin
    acc_sum     = acc_q + ACC_INC;
    acc_d       = acc_sum;
    pit_clock_d = pit_clock_q;
    if (acc_sum >= ACC_WRAP) begin
      acc_d       = acc_sum - ACC_WRAP;
      pit_clock_d = ~pit_clock_q;
    end
  end

  always_comb begin
    pit_gate_d  = {gate2_in, 2'b11};
    out0_prev_d = cnt_out[0];
    irq0_d      = cnt_out[0] & ~out0_prev_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_in_q      <= 8'h00;
      set_mode_q     <= 3'b000;
      latch_count_q  <= 3'b000;
      latch_status_q <= 3'b000;
      write_q        <= 3'b000;
      read_q         <= 3'b000;
      rd_data_q      <= 8'h00;
      rd_valid_q     <= 1'b0;
      acc_q          <= 32'd0;
      pit_clock_q    <= 1'b0;
      pit_gate_q     <= 3'b011;
      out0_prev_q    <= 1'b1;
      irq0_q         <= 1'b0;
    end else begin
      data_in_q      <= data_in_d;
      set_mode_q     <= set_mode_d;
      latch_count_q  <= latch_count_d;
      latch_status_q <= latch_status_d;
      write_q        <= write_d;
      read_q         <= read_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      acc_q          <= acc_d;
      pit_clock_q    <= pit_clock_d;
      pit_gate_q     <= pit_gate_d;
      out0_prev_q    <= out0_prev_d;
      irq0_q         <= irq0_d;
    end
  end

  assign cnt_data_in      = data_in_q;
  assign cnt_set_mode     = set_mode_q;
  assign cnt_latch_count  = latch_count_q;
  assign cnt_latch_status = latch_status_q;
  assign cnt_write        = write_q;
  assign cnt_read         = read_q;
  assign io_readdata      = rd_data_q;
  assign io_readdatavalid = rd_valid_q;
  assign pit_clock        = pit_clock_q;
  assign pit_gate         = pit_gate_q;
  assign irq0             = irq0_q;

endmodule

// File: tb/tb_pit_8254_ctrl.sv
// Directed bench for pit_8254_ctrl: bus decode, read mux, divider rate and IRQ0 edge detect.
module tb_pit_8254_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  io_address;
  logic        io_write;
  logic        io_read;
  logic [7:0]  io_writedata;
  logic [7:0]  io_readdata;
  logic        io_readdatavalid;
  logic        gate2_in;
  logic [7:0]  cnt_data_in;
  logic [2:0]  cnt_set_mode;
  logic [2:0]  cnt_latch_count;
  logic [2:0]  cnt_latch_status;
  logic [2:0]  cnt_write;
  logic [2:0]  cnt_read;
  logic [23:0] cnt_data_out;
  logic [2:0]  cnt_out;
  logic        pit_clock;
  logic [2:0]  pit_gate;
  logic        irq0;

  int unsigned n_cmp;
  int unsigned n_err;
  logic [7:0]  exp_q[$];

  pit_8254_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .io_address       (io_address),
    .io_write         (io_write),
    .io_read          (io_read),
    .io_writedata     (io_writedata),
    .io_readdata      (io_readdata),
    .io_readdatavalid (io_readdatavalid),
    .gate2_in         (gate2_in),
    .cnt_data_in      (cnt_data_in),
    .cnt_set_mode     (cnt_set_mode),
    .cnt_latch_count  (cnt_latch_count),
    .cnt_latch_status (cnt_latch_status),
    .cnt_write        (cnt_write),
    .cnt_read         (cnt_read),
    .cnt_data_out     (cnt_data_out),
    .cnt_out          (cnt_out),
    .pit_clock        (pit_clock),
    .pit_gate         (pit_gate),
    .irq0             (irq0)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change at negedge, outputs for T+1 are inspected at the next negedge.
  task automatic bus_access(input logic [1:0] a, input logic [7:0] d,
                            input logic wr, input logic rd);
    @(negedge clk);
    io_address   = a;
    io_writedata = d;
    io_write     = wr;
    io_read      = rd;
    @(negedge clk);
    io_write     = 1'b0;
    io_read      = 1'b0;
  endtask

  task automatic check_strobes(input string tag, input logic [2:0] sm, input logic [2:0] lc,
                               input logic [2:0] ls, input logic [2:0] wr, input logic [2:0] rd);
    check({tag, "_set_mode"},     {29'd0, cnt_set_mode},     {29'd0, sm});
    check({tag, "_latch_count"},  {29'd0, cnt_latch_count},  {29'd0, lc});
    check({tag, "_latch_status"}, {29'd0, cnt_latch_status}, {29'd0, ls});
    check({tag, "_write"},        {29'd0, cnt_write},        {29'd0, wr});
    check({tag, "_read"},         {29'd0, cnt_read},         {29'd0, rd});
  endtask

  // Scoreboard: expected read data is queued at issue and popped on io_readdatavalid.
  task automatic read_and_score(input string tag, input logic [1:0] a, input logic [7:0] exp,
                                input logic also_write);
    exp_q.push_back(exp);
    bus_access(a, 8'h00, also_write, 1'b1);
    check({tag, "_valid"}, {31'd0, io_readdatavalid}, 32'd1);
    if (io_readdatavalid && exp_q.size() > 0) begin
      check({tag, "_data"}, {24'd0, io_readdata}, {24'd0, exp_q.pop_front()});
    end
  endtask

  initial begin
    int unsigned edges, run, min_run, max_run, runs, pulses, high_cycles;
    logic prev_clk, prev_irq;
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    io_address = 2'd0;
    io_write = 1'b0;
    io_read = 1'b0;
    io_writedata = 8'h00;
    gate2_in = 1'b0;
    cnt_data_out = 24'h000000;
    cnt_out = 3'b000;
    repeat (3) @(negedge clk);

    check("rst_pit_clock", {31'd0, pit_clock}, 32'd0);
    check("rst_pit_gate", {29'd0, pit_gate}, 32'h3);
    check("rst_valid", {31'd0, io_readdatavalid}, 32'd0);
    check("rst_irq0", {31'd0, irq0}, 32'd0);
    check("rst_readdata", {24'd0, io_readdata}, 32'd0);
    check_strobes("rst", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    reset_n = 1'b1;
    @(negedge clk);
    check_strobes("post_rst", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    gate2_in = 1'b1;
    @(negedge clk);
    check("gate2_high", {29'd0, pit_gate}, 32'h7);
    gate2_in = 1'b0;

    // Mode word then LSB/MSB to counter 0
    bus_access(2'd3, 8'h34, 1'b1, 1'b0);
    check_strobes("mode34", 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    check("mode34_data", {24'd0, cnt_data_in}, 32'h34);
    bus_access(2'd0, 8'h9C, 1'b1, 1'b0);
    check_strobes("wr9c", 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    check("wr9c_data", {24'd0, cnt_data_in}, 32'h9C);
    bus_access(2'd0, 8'h2E, 1'b1, 1'b0);
    check_strobes("wr2e", 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    check("wr2e_data", {24'd0, cnt_data_in}, 32'h2E);
    @(negedge clk);
    check_strobes("idle", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    bus_access(2'd2, 8'h11, 1'b1, 1'b0);
    check_strobes("wr_ctr2", 3'b000, 3'b000, 3'b000, 3'b100, 3'b000);
    bus_access(2'd3, 8'h40, 1'b1, 1'b0);
    check_strobes("latch_ctr1", 3'b000, 3'b010, 3'b000, 3'b000, 3'b000);
    bus_access(2'd3, 8'hB6, 1'b1, 1'b0);
    check_strobes("mode_ctr2", 3'b100, 3'b000, 3'b000, 3'b000, 3'b000);

    // Read-back commands
    bus_access(2'd3, 8'hC2, 1'b1, 1'b0);
    check_strobes("rb_c2", 3'b000, 3'b001, 3'b001, 3'b000, 3'b000);
    bus_access(2'd3, 8'hEE, 1'b1, 1'b0);
    check_strobes("rb_ee", 3'b000, 3'b000, 3'b111, 3'b000, 3'b000);
    bus_access(2'd3, 8'hDC, 1'b1, 1'b0);
    check_strobes("rb_dc", 3'b000, 3'b110, 3'b000, 3'b000, 3'b000);
    bus_access(2'd3, 8'hC0, 1'b1, 1'b0);
    check_strobes("rb_none", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    // Reads
    cnt_data_out = 24'h3C_5A_A5;
    read_and_score("rd40", 2'd0, 8'hA5, 1'b0);
    check("rd40_cnt_read", {29'd0, cnt_read}, 32'h1);
    read_and_score("rd41", 2'd1, 8'h5A, 1'b0);
    check("rd41_cnt_read", {29'd0, cnt_read}, 32'h2);
    read_and_score("rd42", 2'd2, 8'h3C, 1'b0);
    check("rd42_cnt_read", {29'd0, cnt_read}, 32'h4);
    read_and_score("rd43", 2'd3, 8'hFF, 1'b0);
    check("rd43_cnt_read", {29'd0, cnt_read}, 32'h0);
    @(negedge clk);
    check("valid_drop", {31'd0, io_readdatavalid}, 32'd0);

    // Simultaneous read and write
    read_and_score("rdwr", 2'd1, 8'hFF, 1'b1);
    check_strobes("rdwr", 3'b000, 3'b000, 3'b000, 3'b010, 3'b000);

    // Reset asserted while a strobe is pending, then a normal access after release
    @(negedge clk);
    io_address = 2'd0; io_writedata = 8'h77; io_write = 1'b1; io_read = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    io_write = 1'b0; io_read = 1'b0;
    check_strobes("rst_mid", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    check("rst_mid_valid", {31'd0, io_readdatavalid}, 32'd0);
    reset_n = 1'b1;
    bus_access(2'd1, 8'h55, 1'b1, 1'b0);
    check_strobes("after_rst", 3'b000, 3'b000, 3'b000, 3'b010, 3'b000);
    check("after_rst_data", {24'd0, cnt_data_in}, 32'h55);

    // Divider: 50000 clks -> 1193.18 rising edges, levels of 20 or 21 clks
    edges = 0; run = 0; runs = 0; min_run = 1000; max_run = 0;
    prev_clk = pit_clock;
    for (int c = 0; c < 50000; c++) begin
      @(negedge clk);
      run++;
      if (pit_clock != prev_clk) begin
        if (pit_clock) edges++;
        if (runs > 0) begin
          if (run < min_run) min_run = run;
          if (run > max_run) max_run = run;
        end
        runs++;
        run = 0;
      end
      prev_clk = pit_clock;
    end
    check("pit_edges_in_range", {31'd0, (edges >= 1192 && edges <= 1194)}, 32'd1);
    check("pit_level_min", min_run, 32'd20);
    check("pit_level_max", max_run, 32'd21);

    // IRQ0: two rising edges on cnt_out[0] with a long high level between them
    pulses = 0; high_cycles = 0; prev_irq = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (irq0) high_cycles++;
      if (irq0 && !prev_irq) pulses++;
      prev_irq = irq0;
      if (c == 2)   cnt_out[0] = 1'b1;
      if (c == 102) cnt_out[0] = 1'b0;
      if (c == 105) cnt_out[0] = 1'b1;
    end
    check("irq0_pulses", pulses, 32'd2);
    check("irq0_high_cycles", high_cycles, 32'd2);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
